uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter: internal baud generator, FIFO and frame FSM.

---
 rtl/uart_tx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with built-in baud divider, push FIFO and start/data/parity/stop FSM.
// Optional CTS flow control is compiled in with `define UART_TX_CTS_EN.
module uart_tx_fifo #(
   parameter int CLK_HZ     = 48000000,
   parameter int BAUD       = 1000000,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          mclk,
   input  logic                          reset_n,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          data_strobe,
   output logic                          ready,
   output logic                          serial,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
`ifdef UART_TX_CTS_EN
   ,
   input  logic                          cts_n
`endif
);

   localparam int DIVISOR = CLK_HZ / BAUD;
   localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int IDX_W   = 3;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIVISOR - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 serial_q, serial_d;
   logic                 overflow_q, overflow_d;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;

   logic                 push;
   logic                 pop;
   logic                 send_ok;
   logic                 start_ok;
   logic                 load_frame;
   logic [DATA_BITS-1:0] head;
   logic                 head_parity;

`ifdef UART_TX_CTS_EN
   logic cts_meta_q;
   logic cts_sync_q;

   // Both sync flops reset to "not clear to send" so nothing leaves before CTS is seen.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         cts_meta_q <= cts_n;
         cts_sync_q <= cts_meta_q;
      end
   end

   assign send_ok = ~cts_sync_q;
`else
   assign send_ok = 1'b1;
`endif

   // ready uses the pre-edge count, so a push into a full FIFO is dropped even on a pop edge.
   assign ready       = (count_q != FULL_COUNT);
   assign push        = data_strobe && ready;
   assign overflow_d  = data_strobe && !ready;
   assign start_ok    = (count_q != '0) && send_ok;
   assign head        = mem_q[rd_ptr_q];
   assign head_parity = (PARITY == 1) ? ~^head : ^head;

   always_comb begin
      // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      serial_d   = serial_q;
      load_frame = 1'b0;
      pop        = 1'b0;

      if (state_q == S_IDLE) begin
         load_frame = start_ok;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         cnt_d = CNT_RELOAD;
         case (state_q)
            S_START: begin
               state_d  = S_DATA;
               idx_d    = '0;
               serial_d = shift_q[0];
               shift_d  = shift_q >> 1;
            end
            S_DATA: begin
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
                  if (PARITY != 0) begin
                     state_d  = S_PARITY;
                     serial_d = parity_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  idx_d    = idx_q + 1'b1;
                  serial_d = shift_q[0];
                  shift_d  = shift_q >> 1;
               end
            end
            S_PARITY: begin
               state_d  = S_STOP;
               idx_d    = '0;
               serial_d = 1'b1;
            end
            S_STOP: begin
               if (idx_q == LAST_STOP) begin
                  idx_d = '0;
                  if (start_ok) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               serial_d = 1'b1;
            end
         endcase
      end

      // The start edge pops the head, drops the line and starts the first bit period.
      if (load_frame) begin
         pop      = 1'b1;
         state_d  = S_START;
         cnt_d    = CNT_RELOAD;
         idx_d    = '0;
         shift_d  = head;
         parity_d = head_parity;
         serial_d = 1'b0;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge mclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         serial_q   <= 1'b1;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         serial_q   <= serial_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign serial     = serial_q;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 8E2, 8N1 with a 4-deep FIFO)
// on one clock; expected line levels are queued per cycle when bytes are pushed.
module tb_uart_tx_fifo;

   localparam int DIV = 4;

   logic mclk;
   logic reset_n;
   logic cts_n;

   logic [7:0] a_data;
   logic       a_stb, a_ready, a_serial, a_busy, a_ovf;
   logic [4:0] a_count;

   logic [7:0] b_data;
   logic       b_stb, b_ready, b_serial, b_busy, b_ovf;
   logic [4:0] b_count;

   logic [7:0] c_data;
   logic       c_stb, c_ready, c_serial, c_busy, c_ovf;
   logic [2:0] c_count;

   logic exp_q[$];
   int   vectors;
   int   miscompares;

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   uart_tx_fifo #(.CLK_HZ(8), .BAUD(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
      .mclk(mclk), .reset_n(reset_n), .data(a_data), .data_strobe(a_stb), .ready(a_ready),
      .serial(a_serial), .busy(a_busy), .fifo_count(a_count), .overflow(a_ovf)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   uart_tx_fifo #(.CLK_HZ(8), .BAUD(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
      .mclk(mclk), .reset_n(reset_n), .data(b_data), .data_strobe(b_stb), .ready(b_ready),
      .serial(b_serial), .busy(b_busy), .fifo_count(b_count), .overflow(b_ovf)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   uart_tx_fifo #(.CLK_HZ(8), .BAUD(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
      .mclk(mclk), .reset_n(reset_n), .data(c_data), .data_strobe(c_stb), .ready(c_ready),
      .serial(c_serial), .busy(c_busy), .fifo_count(c_count), .overflow(c_ovf)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   // Reference frame: start, data LSB first, optional parity, stop bits; DIV cycles each.
   function automatic void expect_frame(input logic [7:0] b, input int parity, input int stops);
      logic [7:0] v;
      v = b;
      repeat (DIV) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (DIV) exp_q.push_back(v[i]);
      if (parity == 1) repeat (DIV) exp_q.push_back(~(^v));
      if (parity == 2) repeat (DIV) exp_q.push_back(^v);
      repeat (stops * DIV) exp_q.push_back(1'b1);
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      vectors++;
      if (a_serial !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_count !== 5'd0 || a_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_a: serial=%b ready=%b busy=%b count=%0d ovf=%b, want 1 1 0 0 0",
                  a_serial, a_ready, a_busy, a_count, a_ovf);
      end
      vectors++;
      if (b_serial !== 1'b1 || c_serial !== 1'b1 || c_ready !== 1'b1 || c_count !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_bc: b_serial=%b c_serial=%b c_ready=%b c_count=%0d, want 1 1 1 0",
                  b_serial, c_serial, c_ready, c_count);
      end
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_8n1();
      logic e;
      a_data = 8'hA5;
      a_stb  = 1'b1;
      expect_frame(8'hA5, 0, 1);
      tick();
      a_stb = 1'b0;
      vectors++;
      if (a_serial !== 1'b1 || a_count !== 5'd1 || a_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL 8n1_push: serial=%b count=%0d busy=%b, want 1 1 1", a_serial, a_count, a_busy);
      end
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (a_serial !== e) begin
            miscompares++;
            $display("FAIL 8n1_bit cycle %0d: serial=%b want %b", cyc, a_serial, e);
         end
      end
      tick();
      vectors++;
      if (a_busy !== 1'b0 || a_serial !== 1'b1 || a_count !== 5'd0) begin
         miscompares++;
         $display("FAIL 8n1_done: busy=%b serial=%b count=%0d, want 0 1 0", a_busy, a_serial, a_count);
      end
   endtask

   task automatic test_parity_2stop();
      logic e;
      b_data = 8'h07;
      b_stb  = 1'b1;
      expect_frame(8'h07, 2, 2);
      tick();
      b_stb = 1'b0;
      for (int cyc = 1; cyc <= 48; cyc++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (b_serial !== e) begin
            miscompares++;
            $display("FAIL 8e2_bit cycle %0d: serial=%b want %b", cyc, b_serial, e);
         end
         if (cyc == 48) begin
            vectors++;
            if (b_busy !== 1'b1) begin
               miscompares++;
               $display("FAIL 8e2_last: busy=%b want 1", b_busy);
            end
         end
      end
      tick();
      vectors++;
      if (b_busy !== 1'b0 || b_serial !== 1'b1) begin
         miscompares++;
         $display("FAIL 8e2_done: busy=%b serial=%b, want 0 1", b_busy, b_serial);
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      a_data = 8'h3C;
      a_stb  = 1'b1;
      expect_frame(8'h3C, 0, 1);
      tick();
      for (int cyc = 1; cyc <= 120; cyc++) begin
         if (cyc == 1) begin
            a_data = 8'h81;
            expect_frame(8'h81, 0, 1);
         end else if (cyc == 2) begin
            a_data = 8'hF0;
            expect_frame(8'hF0, 0, 1);
         end else begin
            a_stb = 1'b0;
         end
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (a_serial !== e) begin
            miscompares++;
            $display("FAIL b2b_bit cycle %0d: serial=%b want %b", cyc, a_serial, e);
         end
         if (cyc == 2 || cyc == 41 || cyc == 81) begin
            vectors++;
            if (a_count !== ((cyc == 2) ? 5'd2 : (cyc == 41) ? 5'd1 : 5'd0)) begin
               miscompares++;
               $display("FAIL b2b_count cycle %0d: count=%0d", cyc, a_count);
            end
         end
      end
      tick();
      vectors++;
      if (a_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_done: busy=%b want 0", a_busy);
      end
   endtask

   task automatic test_overflow();
      logic       e;
      int         pulses;
      logic [2:0] cnt_exp [6];
      cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      pulses  = 0;
      for (int i = 0; i < 6; i++) begin
         c_data = 8'h11 * 8'(i + 1);
         c_stb  = 1'b1;
         if (i < 5) expect_frame(c_data, 0, 1);
         tick();
         if (c_ovf === 1'b1) pulses++;
         if (i > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (c_serial !== e) begin
               miscompares++;
               $display("FAIL ovf_bit cycle %0d: serial=%b want %b", i, c_serial, e);
            end
         end
         vectors++;
         if (c_count !== cnt_exp[i] || c_ready !== (cnt_exp[i] != 3'd4) || c_ovf !== (i == 5)) begin
            miscompares++;
            $display("FAIL ovf_push %0d: count=%0d ready=%b ovf=%b, want %0d %b %b",
                     i, c_count, c_ready, c_ovf, cnt_exp[i], cnt_exp[i] != 3'd4, i == 5);
         end
      end
      c_stb = 1'b0;
      for (int cyc = 6; cyc <= 200; cyc++) begin
         tick();
         if (c_ovf === 1'b1) pulses++;
         e = exp_q.pop_front();
         vectors++;
         if (c_serial !== e) begin
            miscompares++;
            $display("FAIL ovf_bit cycle %0d: serial=%b want %b", cyc, c_serial, e);
         end
      end
      tick();
      vectors++;
      if (pulses != 1 || c_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_done: pulses=%0d busy=%b, want 1 0", pulses, c_busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic e;
      a_data = 8'h5A;
      a_stb  = 1'b1;
      expect_frame(8'h5A, 0, 1);
      tick();
      a_data = 8'hC3;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         tick();
         a_stb = 1'b0;
         e = exp_q.pop_front();
         vectors++;
         if (a_serial !== e) begin
            miscompares++;
            $display("FAIL rst_bit cycle %0d: serial=%b want %b", cyc, a_serial, e);
         end
      end
      exp_q.delete();
      reset_n = 1'b0;
      #1;
      vectors++;
      if (a_serial !== 1'b1 || a_count !== 5'd0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_async: serial=%b count=%0d busy=%b ready=%b, want 1 0 0 1",
                  a_serial, a_count, a_busy, a_ready);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         tick();
         vectors++;
         if (a_serial !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_quiet cycle %0d: serial=%b busy=%b, want 1 0", cyc, a_serial, a_busy);
         end
      end
   endtask

`ifdef UART_TX_CTS_EN
   task automatic test_cts();
      logic e;
      cts_n = 1'b1;
      repeat (3) tick();
      a_data = 8'hA1;
      a_stb  = 1'b1;
      tick();
      a_data = 8'h1E;
      tick();
      a_stb = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         vectors++;
         if (a_serial !== 1'b1 || a_count !== 5'd2) begin
            miscompares++;
            $display("FAIL cts_hold cycle %0d: serial=%b count=%0d, want 1 2", cyc, a_serial, a_count);
         end
      end
      cts_n = 1'b0;
      for (int cyc = 0; cyc < 2; cyc++) begin
         tick();
         vectors++;
         if (a_serial !== 1'b1) begin
            miscompares++;
            $display("FAIL cts_sync cycle %0d: serial=%b want 1", cyc, a_serial);
         end
      end
      expect_frame(8'hA1, 0, 1);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (a_serial !== e) begin
            miscompares++;
            $display("FAIL cts_bit cycle %0d: serial=%b want %b", cyc, a_serial, e);
         end
         if (cyc == 10) cts_n = 1'b1;
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         vectors++;
         if (a_serial !== 1'b1 || a_count !== 5'd1) begin
            miscompares++;
            $display("FAIL cts_held cycle %0d: serial=%b count=%0d, want 1 1", cyc, a_serial, a_count);
         end
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      cts_n       = 1'b0;
      a_data = '0; a_stb = 1'b0;
      b_data = '0; b_stb = 1'b0;
      c_data = '0; c_stb = 1'b0;
      test_reset();
      test_8n1();
      test_parity_2stop();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
      test_cts();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
